// File: rtl/picorv32_pcpi_lockstep.sv
// Lockstep dispatcher/checker: broadcasts one PCPI request to NUM_CH redundant coprocessors and
// compares their responses. Define PCPI_LOCKSTEP_WAIT_EXTEND_EN to let pcpi_wait extend the timeout.
module picorv32_pcpi_lockstep #(
  parameter int unsigned NUM_CH         = 2,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_insn,
  input  logic [31:0]              req_rs1,
  input  logic [31:0]              req_rs2,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_wr,
  output logic [31:0]              rsp_rd,
  output logic                     rsp_mismatch,
  output logic                     rsp_timeout,
  output logic [NUM_CH-1:0]        pcpi_valid,
  output logic [31:0]              pcpi_insn,
  output logic [31:0]              pcpi_rs1,
  output logic [31:0]              pcpi_rs2,
  input  logic [NUM_CH-1:0]        pcpi_wr,
  input  logic [32*NUM_CH-1:0]     pcpi_rd,
  input  logic [NUM_CH-1:0]        pcpi_wait,
  input  logic [NUM_CH-1:0]        pcpi_ready,
  output logic [CNT_W-1:0]         err_count,
  output logic                     err_flag
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StCollect, StResp} state_e;

  state_e                   state_q, state_d;
  logic [NUM_CH-1:0]        valid_q, valid_d;
  logic [NUM_CH-1:0]        done_q, done_d;
  logic [NUM_CH-1:0]        cap_wr_q, cap_wr_d;
  logic [NUM_CH-1:0][31:0]  cap_rd_q, cap_rd_d;
  logic                     pend_q, pend_d;
  logic [TW-1:0]            timer_q, timer_d;
  logic [31:0]              insn_q, insn_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic                     rsp_wr_q, rsp_wr_d, rsp_mm_q, rsp_mm_d, rsp_to_q, rsp_to_d;
  logic [31:0]              rsp_rd_q, rsp_rd_d;
  logic [CNT_W-1:0]         err_count_q, err_count_d;
  logic                     err_flag_q, err_flag_d;

  logic        ref_found, ref_wr, diff, wait_any;
  logic [31:0] ref_rd;

`ifndef PCPI_LOCKSTEP_WAIT_EXTEND_EN
  logic unused_wait;
  assign unused_wait = ^pcpi_wait;
`endif

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    done_d      = done_q;
    cap_wr_d    = cap_wr_q;
    cap_rd_d    = cap_rd_q;
    pend_d      = pend_q;
    timer_d     = timer_q;
    insn_d      = insn_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rsp_wr_d    = rsp_wr_q;
    rsp_rd_d    = rsp_rd_q;
    rsp_mm_d    = rsp_mm_q;
    rsp_to_d    = rsp_to_q;
    err_count_d = err_count_q;
    err_flag_d  = err_flag_q;
    ref_found   = 1'b0;
    ref_wr      = 1'b0;
    ref_rd      = '0;
    diff        = 1'b0;
    wait_any    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          insn_d  = req_insn;
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          valid_d = '1;
          done_d  = '0;
          pend_d  = 1'b0;
          timer_d = '0;
          state_d = StCollect;
        end
      end
      StCollect: begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (pcpi_ready[i]) begin
            if (!done_q[i]) begin
              cap_wr_d[i] = pcpi_wr[i];
              cap_rd_d[i] = pcpi_rd[32*i +: 32];
              done_d[i]   = 1'b1;
              valid_d[i]  = 1'b0;
            end else if (pcpi_wr[i] != cap_wr_q[i] || pcpi_rd[32*i +: 32] != cap_rd_q[i]) begin
              // A channel that changes its answer on a repeat ready is unstable.
              pend_d = 1'b1;
            end
          end
`ifdef PCPI_LOCKSTEP_WAIT_EXTEND_EN
          if (!done_q[i] && pcpi_wait[i]) wait_any = 1'b1;
`endif
        end
        timer_d = wait_any ? '0 : timer_q + TW'(1);
        if (&done_d) begin
          rsp_to_d = 1'b0;
          state_d  = StResp;
        end else if (timer_d >= TW'(TIMEOUT_CYCLES)) begin
          valid_d  = '0;
          rsp_to_d = 1'b1;
          state_d  = StResp;
        end
        if (state_d == StResp) begin
          // Lowest-index done channel is the reference for the agreement check.
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (done_d[i]) begin
              if (!ref_found) begin
                ref_found = 1'b1;
                ref_wr    = cap_wr_d[i];
                ref_rd    = cap_rd_d[i];
              end else if (cap_wr_d[i] != ref_wr || cap_rd_d[i] != ref_rd) begin
                diff = 1'b1;
              end
            end
          end
          rsp_mm_d = diff | pend_d;
          rsp_wr_d = done_d[0] ? cap_wr_d[0] : 1'b0;
          rsp_rd_d = done_d[0] ? cap_rd_d[0] : 32'd0;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          if (rsp_mm_q || rsp_to_q) begin
            err_flag_d = 1'b1;
            if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      done_q      <= '0;
      cap_wr_q    <= '0;
      cap_rd_q    <= '0;
      pend_q      <= 1'b0;
      timer_q     <= '0;
      insn_q      <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rsp_wr_q    <= 1'b0;
      rsp_rd_q    <= '0;
      rsp_mm_q    <= 1'b0;
      rsp_to_q    <= 1'b0;
      err_count_q <= '0;
      err_flag_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      cap_wr_q    <= cap_wr_d;
      cap_rd_q    <= cap_rd_d;
      pend_q      <= pend_d;
      timer_q     <= timer_d;
      insn_q      <= insn_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rsp_wr_q    <= rsp_wr_d;
      rsp_rd_q    <= rsp_rd_d;
      rsp_mm_q    <= rsp_mm_d;
      rsp_to_q    <= rsp_to_d;
      err_count_q <= err_count_d;
      err_flag_q  <= err_flag_d;
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign rsp_valid    = (state_q == StResp);
  assign rsp_wr       = rsp_wr_q;
  assign rsp_rd       = rsp_rd_q;
  assign rsp_mismatch = rsp_mm_q;
  assign rsp_timeout  = rsp_to_q;
  assign pcpi_valid   = valid_q;
  assign pcpi_insn    = insn_q;
  assign pcpi_rs1     = rs1_q;
  assign pcpi_rs2     = rs2_q;
  assign err_count    = err_count_q;
  assign err_flag     = err_flag_q;

endmodule

// File: tb/tb_picorv32_pcpi_lockstep.sv
// Self-checking bench for picorv32_pcpi_lockstep: a transaction-level model predicts every
// cycle's outputs from per-channel ready schedules; literal checks pin the model.
module tb_picorv32_pcpi_lockstep;
  localparam int NCH = 3;
  localparam int TO  = 40;
  localparam int CW  = 2;
`ifdef PCPI_LOCKSTEP_WAIT_EXTEND_EN
  localparam bit WaitExt = 1'b1;
`else
  localparam bit WaitExt = 1'b0;
`endif
  localparam logic [31:0] InsnMul = 32'h02b50533;

  logic              clk = 1'b0;
  logic              resetn = 1'b1;
  logic              req_valid = 1'b0, req_ready;
  logic [31:0]       req_insn = '0, req_rs1 = '0, req_rs2 = '0;
  logic              rsp_valid, rsp_ready = 1'b0, rsp_wr, rsp_mismatch, rsp_timeout;
  logic [31:0]       rsp_rd;
  logic [NCH-1:0]    pcpi_valid;
  logic [31:0]       pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic [NCH-1:0]    pcpi_wr = '0, pcpi_wait = '0, pcpi_ready = '0;
  logic [32*NCH-1:0] pcpi_rd = '0;
  logic [CW-1:0]     err_count;
  logic              err_flag;

  picorv32_pcpi_lockstep #(.NUM_CH(NCH), .TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready),
    .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_wr(rsp_wr), .rsp_rd(rsp_rd), .rsp_mismatch(rsp_mismatch),
    .rsp_timeout(rsp_timeout), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready), .err_count(err_count), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Per-channel schedule: first ready at offset f (0 = never), optional repeat ready at g.
  int          ev_f[NCH], ev_g[NCH];
  bit          ev_wr[NCH], ev_wr2[NCH], ev_wt[NCH];
  logic [31:0] ev_rd[NCH], ev_rd2[NCH];

  int          t_acc, exp_l, exp_h, exp_err = 0, exp_err_after;
  bit          active = 1'b0, skip_chk = 1'b1, exp_flag = 1'b0, exp_flag_after;
  bit          exp_to, exp_mm, exp_wr;
  logic [31:0] exp_rd, exp_insn, exp_rs1, exp_rs2;
  logic        got_pre, got_valid, got_wr, got_mm, got_to;
  logic [31:0] got_rd;
  logic [NCH-1:0] got_pv;

  task automatic set_ch(input int i, input int f, input bit wr, input logic [31:0] rd,
                        input int g, input bit wr2, input logic [31:0] rd2, input bit wt);
    ev_f[i] = f; ev_wr[i] = wr; ev_rd[i] = rd;
    ev_g[i] = g; ev_wr2[i] = wr2; ev_rd2[i] = rd2; ev_wt[i] = wt;
  endtask

  task automatic model();
    int timer, e;
    bit all, anyw, first, fail, rw;
    logic [31:0] rr;
    timer = 0; e = 0; exp_to = 1'b0;
    for (int k = 1; k <= 2000 && e == 0; k++) begin
      all = 1'b1; anyw = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        if (ev_f[i] == 0 || ev_f[i] > k) all = 1'b0;
        if (ev_wt[i] && (ev_f[i] == 0 || k < ev_f[i])) anyw = 1'b1;
      end
      if (WaitExt && anyw) timer = 0;
      else timer++;
      if (all) e = k;
      else if (timer >= TO) begin e = k; exp_to = 1'b1; end
    end
    exp_l = e + 1;
    first = 1'b1; exp_mm = 1'b0; rw = 1'b0; rr = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ev_f[i] != 0 && ev_f[i] <= e) begin
        if (ev_g[i] > ev_f[i] && ev_g[i] <= e &&
            (ev_wr2[i] != ev_wr[i] || ev_rd2[i] != ev_rd[i])) exp_mm = 1'b1;
        if (first) begin first = 1'b0; rw = ev_wr[i]; rr = ev_rd[i]; end
        else if (ev_wr[i] != rw || ev_rd[i] != rr) exp_mm = 1'b1;
      end
    end
    exp_wr = (ev_f[0] != 0 && ev_f[0] <= e) ? ev_wr[0] : 1'b0;
    exp_rd = (ev_f[0] != 0 && ev_f[0] <= e) ? ev_rd[0] : 32'd0;
    fail = exp_mm | exp_to;
    exp_err_after  = (fail && exp_err < (1 << CW) - 1) ? exp_err + 1 : exp_err;
    exp_flag_after = exp_flag | fail;
  endtask

  task automatic drive_ch(input int k);
    for (int i = 0; i < NCH; i++) begin
      pcpi_ready[i] = (ev_f[i] == k) || (ev_g[i] != 0 && ev_g[i] == k);
      if (ev_f[i] == k) begin
        pcpi_wr[i] = ev_wr[i]; pcpi_rd[32*i +: 32] = ev_rd[i];
      end else if (ev_g[i] == k) begin
        pcpi_wr[i] = ev_wr2[i]; pcpi_rd[32*i +: 32] = ev_rd2[i];
      end else begin
        pcpi_wr[i] = 1'($urandom); pcpi_rd[32*i +: 32] = $urandom;
      end
      pcpi_wait[i] = ev_wt[i] && (ev_f[i] == 0 || k < ev_f[i]);
    end
  endtask

  // Called just after a rising edge with the DUT idle; returns one cycle after rsp handshake.
  task automatic run(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                     input int h);
    model();
    exp_h = h; exp_insn = insn; exp_rs1 = rs1; exp_rs2 = rs2;
    req_valid = 1'b1; req_insn = insn; req_rs1 = rs1; req_rs2 = rs2;
    t_acc = cyc; active = 1'b1;
    for (int k = 1; k <= exp_l + h; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; req_insn = $urandom; req_rs1 = $urandom; req_rs2 = $urandom;
      drive_ch(k);
      rsp_ready = (k == exp_l + h);
      if (k == exp_l - 1) begin @(negedge clk); got_pre = rsp_valid; end
      if (k == exp_l) begin
        @(negedge clk);
        got_valid = rsp_valid; got_wr = rsp_wr; got_rd = rsp_rd;
        got_mm = rsp_mismatch; got_to = rsp_timeout; got_pv = pcpi_valid;
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0; pcpi_ready = '0; pcpi_wait = '0;
    exp_err = exp_err_after; exp_flag = exp_flag_after; active = 1'b0;
  endtask

  always @(negedge clk) begin : cmp
    int k;
    bit busy, in_resp;
    logic [NCH-1:0] pv;
    if (!skip_chk) begin
      k = active ? cyc - t_acc : 0;
      busy    = active && k >= 1 && k <= exp_l + exp_h;
      in_resp = active && k >= exp_l && k <= exp_l + exp_h;
      for (int i = 0; i < NCH; i++)
        pv[i] = active && k >= 1 && k <= exp_l - 1 && (ev_f[i] == 0 || k <= ev_f[i]);
      chk("req_ready", 64'(req_ready), 64'(!busy));
      chk("rsp_valid", 64'(rsp_valid), 64'(in_resp));
      chk("pcpi_valid", 64'(pcpi_valid), 64'(pv));
      chk("err_count", 64'(err_count), 64'(exp_err));
      chk("err_flag", 64'(err_flag), 64'(exp_flag));
      if (pv != '0) begin
        chk("pcpi_insn", 64'(pcpi_insn), 64'(exp_insn));
        chk("pcpi_rs1", 64'(pcpi_rs1), 64'(exp_rs1));
        chk("pcpi_rs2", 64'(pcpi_rs2), 64'(exp_rs2));
      end
      if (in_resp) begin
        chk("rsp_wr", 64'(rsp_wr), 64'(exp_wr));
        chk("rsp_rd", 64'(rsp_rd), 64'(exp_rd));
        chk("rsp_mismatch", 64'(rsp_mismatch), 64'(exp_mm));
        chk("rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 resetn = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_pcpi_valid", 64'(pcpi_valid), 64'd0);
    chk("rst_rsp_rd", 64'(rsp_rd), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    skip_chk = 1'b0;
    @(posedge clk); #1;

    // mul (+33) against fast_mul (+4), third copy at +4
    set_ch(0, 33, 1, 42, 0, 0, 0, 1); set_ch(1, 4, 1, 42, 0, 0, 0, 1);
    set_ch(2, 4, 1, 42, 0, 0, 0, 1);
    run(InsnMul, 7, 6, 2);
    chk("t1_valid_T33", 64'(got_pre), 64'd0);
    chk("t1_valid_T34", 64'(got_valid), 64'd1);
    chk("t1_rd", 64'(got_rd), 64'd42);
    chk("t1_wr", 64'(got_wr), 64'd1);
    chk("t1_mm", 64'(got_mm), 64'd0);
    chk("t1_to", 64'(got_to), 64'd0);
    chk("t1_err", 64'(err_count), 64'd0);

    set_ch(0, 33, 1, 42, 0, 0, 0, 0); set_ch(1, 4, 1, 43, 0, 0, 0, 0);
    set_ch(2, 10, 1, 42, 0, 0, 0, 0);
    run(InsnMul, 7, 6, 1);
    chk("t2_mm", 64'(got_mm), 64'd1);
    chk("t2_rd", 64'(got_rd), 64'd42);
    chk("t2_err", 64'(err_count), 64'd1);
    chk("t2_flag", 64'(err_flag), 64'd1);

    set_ch(0, 20, 1, 42, 0, 0, 0, 0); set_ch(1, 4, 1, 42, 7, 1, 0, 0);
    set_ch(2, 5, 1, 42, 0, 0, 0, 0);
    run(InsnMul, 7, 6, 0);
    chk("t3_mm_unstable", 64'(got_mm), 64'd1);

    set_ch(0, 3, 1, 5, 0, 0, 0, 0); set_ch(1, 50, 1, 5, 0, 0, 0, 1);
    set_ch(2, 6, 1, 5, 0, 0, 0, 0);
    run(InsnMul, 1, 5, 1);
    chk("t4_timeout", 64'(got_to), 64'(!WaitExt));
    chk("t4_pv", 64'(got_pv), 64'd0);
    chk("t4_rd", 64'(got_rd), 64'd5);

    set_ch(0, 0, 0, 0, 0, 0, 0, 0); set_ch(1, 2, 1, 9, 0, 0, 0, 0);
    set_ch(2, 3, 1, 8, 0, 0, 0, 0);
    run(InsnMul, 3, 3, 0);
    chk("t5_to", 64'(got_to), 64'd1);
    chk("t5_wr_ch0_absent", 64'(got_wr), 64'd0);
    chk("t5_rd_ch0_absent", 64'(got_rd), 64'd0);
    chk("t5_mm_ref_ch1", 64'(got_mm), 64'd1);

    for (int n = 0; n < 2; n++) begin
      set_ch(0, 1, 1, 32'h100 + n, 0, 0, 0, 0); set_ch(1, 2, 1, 32'h200, 0, 0, 0, 0);
      set_ch(2, 1, 1, 32'h100 + n, 0, 0, 0, 0);
      run(InsnMul, n, 2, n);
    end
    chk("sat_err_count", 64'(err_count), 64'd3);

    set_ch(0, 1, 0, 32'hdeadbeef, 0, 0, 0, 0); set_ch(1, 1, 0, 32'hdeadbeef, 0, 0, 0, 0);
    set_ch(2, 1, 0, 32'hdeadbeef, 0, 0, 0, 0);
    run(32'h0, 32'hffff_ffff, 32'h8000_0000, 0);
    chk("min_lat_T1", 64'(got_pre), 64'd0);
    chk("min_lat_T2", 64'(got_valid), 64'd1);
    chk("min_lat_rd", 64'(got_rd), 64'hdeadbeef);
    chk("min_lat_sat_hold", 64'(err_count), 64'd3);

    // Reset in the middle of a transaction
    skip_chk = 1'b1;
    req_valid = 1'b1; req_insn = InsnMul; req_rs1 = 9; req_rs2 = 9;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    chk("mid_collect_pv", 64'(pcpi_valid), 64'h7);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_pv", 64'(pcpi_valid), 64'd0);
    chk("async_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("async_rst_err", 64'(err_count), 64'd0);
    @(posedge clk); #1 resetn = 1'b1;
    exp_err = 0; exp_flag = 1'b0; active = 1'b0; skip_chk = 1'b0;
    repeat (45) begin @(posedge clk); #1; end
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    set_ch(0, 6, 1, 15, 0, 0, 0, 0); set_ch(1, 2, 1, 15, 0, 0, 0, 0);
    set_ch(2, 9, 1, 15, 0, 0, 0, 0);
    run(InsnMul, 3, 5, 1);
    chk("recover_rd", 64'(got_rd), 64'd15);
    chk("recover_mm", 64'(got_mm), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/picorv32_pcpi_lockstep.md
# picorv32_pcpi_lockstep

Lockstep dispatcher and checker for NUM_CH PCPI coprocessor channels, for example `picorv32_pcpi_mul` and `picorv32_pcpi_fast_mul` side by side.
- Accepts one request from the host, broadcasts it to all channels and collects each channel's response at its own latency.
- Returns the channel-0 result, a mismatch flag and a timeout flag, and keeps a saturating error counter.
- Sits between a PCPI master (core or bench driver) and redundant coprocessor instances.

## Interface
Parameters:
- NUM_CH, 2: number of channels, legal range 2..8.
- TIMEOUT_CYCLES, 64: COLLECT cycles allowed before timeout, legal range 1..65535.
- CNT_W, 16: width of err_count.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  host request valid.
- req_ready  out  1  high only in IDLE.
- req_insn, req_rs1, req_rs2  in  32 each  request operands.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  host accepts the result.
- rsp_wr  out  1  channel-0 pcpi_wr.
- rsp_rd  out  32  channel-0 pcpi_rd.
- rsp_mismatch  out  1  channel disagreement or instability.
- rsp_timeout  out  1  at least one channel never responded.
- pcpi_valid  out  NUM_CH  per-channel valid.
- pcpi_insn, pcpi_rs1, pcpi_rs2  out  32 each  broadcast operands, held for the whole transaction.
- pcpi_wr  in  NUM_CH  per-channel write flag.
- pcpi_rd  in  32*NUM_CH  per-channel result; channel i occupies bits [32i+31:32i].
- pcpi_wait  in  NUM_CH  per-channel wait.
- pcpi_ready  in  NUM_CH  per-channel ready.
- err_count  out  CNT_W  count of failed transactions; saturates at all-ones.
- err_flag  out  1  sticky; set on the first failed transaction.

## Operation
The block is a three-state FSM: IDLE, COLLECT, RESP.

IDLE
- req_ready=1.
- On req_valid: latch the operands, set all pcpi_valid bits, clear the done[] bits, clear the timer, go to COLLECT.

COLLECT, per channel i, evaluated every cycle:
- pcpi_ready[i] with done[i]=0: capture wr_i and rd_i, set done[i], clear pcpi_valid[i].
- pcpi_ready[i] with done[i]=1 (repeat ready): if pcpi_wr or pcpi_rd differs from the captured value, set the pending mismatch bit.
- Simultaneous readies on several channels are all captured in the same cycle.

COLLECT, timer and exit:
- The timer increments every COLLECT cycle.
- If all done[] bits are set (including readies sampled this cycle): go to RESP, timeout=0.
- Else, if the timer reaches TIMEOUT_CYCLES: clear all pcpi_valid, go to RESP with timeout=1.

Result computation on entry to RESP:
- Reference channel = lowest-index done channel.
- Mismatch = any done channel whose {wr,rd} differs from the reference, OR'd with the pending mismatch bit.
- rsp_wr/rsp_rd = channel 0's captured values if done[0]=1, otherwise 0.

RESP
- rsp_valid=1. Outputs stay stable until rsp_ready.
- On rsp_ready: go to IDLE.
- If rsp_mismatch or rsp_timeout: err_count increments (saturating) and err_flag is set.

Reset values:
- All outputs 0, except req_ready=1.
- FSM=IDLE, done[]=0, timer=0, err_count=0, err_flag=0.

Reset mid-transaction: pcpi_valid drops asynchronously; any in-flight result is discarded and no rsp_valid is issued.

## Timing
- Request accepted at cycle T: pcpi_valid is high from T+1.
- Last channel's first ready sampled at cycle C: pcpi_valid[i] is low and rsp_valid is high at C+1.
- Minimum latency, req accept to rsp_valid: 2 cycles (all channels ready at T+1).
- Timeout: rsp_valid is high at T+1+TIMEOUT_CYCLES.
- rsp_ready sampled at R: req_ready is high at R+1.
- Back-to-back throughput is one transaction per (latency+1) cycles.
- Operands sampled only on acceptance; host changes afterwards have no effect.

## Configuration
- PCPI_LOCKSTEP_WAIT_EXTEND_EN defined: any not-done channel asserting pcpi_wait clears the timer that cycle. A channel that holds wait high therefore never times out.
- Undefined: pcpi_wait is ignored and the timeout is a hard limit measured from acceptance.

## Test plan
- NUM_CH=2, mul (ready at +33) and fast_mul (ready at +4); insn=MUL, rs1=7, rs2=6 -> rsp_valid at T+34, rsp_rd=42, rsp_wr=1, mismatch=0, timeout=0, err_count=0.
- Channel 1 returns rd=43 against channel 0's 42 -> rsp_mismatch=1, rsp_rd=42, err_count=1, err_flag=1.
- Channel 1 raises ready again 3 cycles after done with rd=0 while channel 0 is still pending -> rsp_mismatch=1.
- TIMEOUT_CYCLES=8, channel 1 never ready, macro undefined -> rsp_valid at T+9, timeout=1, pcpi_valid=0. With the macro defined and wait[1] held high, no timeout occurs.
- CNT_W=2, five consecutive mismatching transactions -> err_count reads 3 and holds there.
- resetn pulsed low mid-COLLECT -> pcpi_valid=0 immediately, no rsp_valid, req_ready=1 after release, err_count=0.
